// File: rtl/spmul_mac_seq.sv
// Initiator-side sequencer for a shared SPMUL: walks a bank of sig/coef pairs,
// issues one multiply per tap and accumulates a saturated 16-bit dot product.
module spmul_mac_seq #(
    parameter int NTAPS   = 12,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_an,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_sig,
    input  logic [9:0]  wr_coef,
    input  logic        go,
    output logic        busy,
    output logic [15:0] y_out,
    output logic        y_valid,
    output logic        err,
    output logic        mul_start,
    output logic [15:0] mul_sig,
    output logic [9:0]  mul_coef,
    input  logic [15:0] mul_result,
    input  logic        mul_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // The timeout counter only has to hold 0..TIMEOUT-1.
    localparam int            TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    IDX_LAST = 4'(NTAPS - 1);
    localparam logic [4:0]    NTAPS_W  = 5'(NTAPS);

    function automatic logic [15:0] sat16(input logic signed [19:0] v);
        logic [15:0] r;
        if (v > 20'sd32767) begin
            r = 16'h7FFF;
        end else if (v < -20'sd32768) begin
            r = 16'h8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    state_t             state_r, state_nx_s;
    logic signed [19:0] acc_r, acc_nx_s;
    logic [3:0]         idx_r, idx_nx_s;
    logic [TW-1:0]      tmo_r, tmo_nx_s;
    logic [15:0]        y_out_r, y_out_nx_s;
    logic               y_valid_r, y_valid_nx_s;
    logic               err_r, err_nx_s;
    logic               busy_r, mul_start_r;
    logic [15:0]        mul_sig_r;
    logic [9:0]         mul_coef_r;
    logic               bank_we_s;
    logic [15:0]        op_sig_s;
    logic [9:0]         op_coef_s;
    logic [15:0]        bank_sig_r  [16];
    logic [9:0]         bank_coef_r [16];

    // Next-state, accumulator and result computation for the run sequencer.
    always_comb begin
        state_nx_s   = state_r;
        acc_nx_s     = acc_r;
        idx_nx_s     = idx_r;
        tmo_nx_s     = tmo_r;
        y_out_nx_s   = y_out_r;
        y_valid_nx_s = 1'b0;
        err_nx_s     = 1'b0;
        bank_we_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bank_we_s = wr_en && ({1'b0, wr_addr} < NTAPS_W);
                if (go) begin
                    acc_nx_s   = 20'sd0;
                    idx_nx_s   = 4'd0;
                    tmo_nx_s   = TW'(0);
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A completion on the last allowed cycle still counts.
                if (mul_done) begin
                    acc_nx_s   = acc_r + {{4{mul_result[15]}}, mul_result};
                    state_nx_s = ST_GAP;
                end else if (tmo_r == TMO_LAST) begin
                    err_nx_s   = 1'b1;
                    acc_nx_s   = 20'sd0;
                    state_nx_s = ST_IDLE;
                end else begin
                    tmo_nx_s   = tmo_r + TW'(1);
                end
            end
            ST_GAP: begin
                if (mul_done) begin
                    state_nx_s = ST_GAP;
                end else if (idx_r == IDX_LAST) begin
                    y_out_nx_s   = sat16(acc_r);
                    y_valid_nx_s = 1'b1;
                    state_nx_s   = ST_FINISH;
                end else begin
                    idx_nx_s   = idx_r + 4'd1;
                    tmo_nx_s   = TW'(0);
                    state_nx_s = ST_RUN;
                end
            end
            ST_FINISH: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Operand fetch; a write in the go cycle is forwarded so the run sees it.
    always_comb begin
        if (bank_we_s && (wr_addr == idx_nx_s)) begin
            op_sig_s  = wr_sig;
            op_coef_s = wr_coef;
        end else begin
            op_sig_s  = bank_sig_r[idx_nx_s];
            op_coef_s = bank_coef_r[idx_nx_s];
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_an) begin
            state_r     <= ST_IDLE;
            acc_r       <= 20'sd0;
            idx_r       <= 4'd0;
            tmo_r       <= TW'(0);
            y_out_r     <= 16'h0000;
            y_valid_r   <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            mul_start_r <= 1'b0;
            mul_sig_r   <= 16'h0000;
            mul_coef_r  <= 10'h000;
        end else begin
            state_r     <= state_nx_s;
            acc_r       <= acc_nx_s;
            idx_r       <= idx_nx_s;
            tmo_r       <= tmo_nx_s;
            y_out_r     <= y_out_nx_s;
            y_valid_r   <= y_valid_nx_s;
            err_r       <= err_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            mul_start_r <= (state_nx_s == ST_RUN);
            if (state_nx_s == ST_RUN) begin
                mul_sig_r  <= op_sig_s;
                mul_coef_r <= op_coef_s;
            end else begin
                mul_sig_r  <= mul_sig_r;
                mul_coef_r <= mul_coef_r;
            end
        end
    end

    // Coefficient/signal bank; entries at or above NTAPS are never written.
    always_ff @(posedge clk) begin
        if (!rst_an) begin
            for (int i = 0; i < 16; i++) begin
                bank_sig_r[i]  <= 16'h0000;
                bank_coef_r[i] <= 10'h000;
            end
        end else if (bank_we_s) begin
            bank_sig_r[wr_addr]  <= wr_sig;
            bank_coef_r[wr_addr] <= wr_coef;
        end else begin
            bank_sig_r[wr_addr]  <= bank_sig_r[wr_addr];
            bank_coef_r[wr_addr] <= bank_coef_r[wr_addr];
        end
    end

    assign busy      = busy_r;
    assign y_out     = y_out_r;
    assign y_valid   = y_valid_r;
    assign err       = err_r;
    assign mul_start = mul_start_r;
    assign mul_sig   = mul_sig_r;
    assign mul_coef  = mul_coef_r;

endmodule
